pwm_ramp_sequencer: RTL and testbench
=====================================

// Module: pwm_ramp_sequencer
// PURPOSE
//  Parametrised successor to the fixed-value PWM sequencer. Drives the PWM
//  core's top/compare load interface with a time-varying duty ramp
//  (sawtooth, triangle "breathing", or one-shot fade-in) instead of a constant.
//  Sits between the control/config logic and the PWM counter core. Steps the
//  compare value once every HOLD_PERIODS PWM periods, using a valid/ready
//  handshake on each load.
// PARAMETERS
//  TOP_WIDTH      8    width of o_top
//  CMP_WIDTH      9    width of o_compare (TOP_WIDTH+1 so TOP_VALUE+1 = 100% duty)
//  TOP_VALUE      255  period top value presented on o_top
//  STEP           1    compare increment/decrement per step (>=1, <=TOP_VALUE+1)
//  HOLD_PERIODS   4    i_period_end strobes per step (>=1)
//  STARTUP_DELAY  4    clocks after reset before the first load
// PORTS
//  i_clk            in   1          system clock
//  i_reset          in   1          async active-high reset
//  i_enable         in   1          1 = ramp advances; 0 = freeze at current step
//  i_mode           in   2          0 HOLD, 1 SAW, 2 TRIANGLE, 3 ONESHOT
//  i_period_end     in   1          1-clk strobe from PWM core at end of each period
//  i_ready          in   1          PWM core accepts top/compare this clock
//  o_top            out  TOP_WIDTH  constant TOP_VALUE
//  o_top_valid      out  1          top load request (initial load only)
//  o_compare        out  CMP_WIDTH  current compare value
//  o_compare_valid  out  1          compare load request
//  o_done           out  1          ONESHOT ramp reached max; sticky until reset
// BEHAVIOUR
//  Reset (async, all regs): state=STARTUP, o_compare=0, o_top_valid=0,
//   o_compare_valid=0, o_done=0, dir=UP, delay/period counters=0. o_top=TOP_VALUE always.
//  FSM states: STARTUP, LOAD_INIT, RUN, SEND, DONE.
//  STARTUP: count clocks; on the STARTUP_DELAY-th clock after reset -> LOAD_INIT.
//  LOAD_INIT: o_top_valid=o_compare_valid=1, o_compare=0; hold until i_ready=1;
//   transfer on the valid&ready clock; next clock both valids=0, -> RUN.
//  RUN: if i_enable, count i_period_end strobes; on the HOLD_PERIODS-th strobe,
//   clear the counter, register next compare (rules below) -> SEND. If !i_enable,
//   counter holds; strobes ignored. Mode HOLD: no step, stay in RUN.
//  SEND: o_compare_valid=1 (o_top_valid=0), o_compare stable; -> RUN on the
//   valid&ready clock. i_period_end in SEND is dropped (not counted).
//  Handshake: valid never deasserts before ready; data stable while valid=1.
//  Next-compare arithmetic (MAX=TOP_VALUE+1, computed CMP_WIDTH+1 wide, no wrap):
//   SAW:      c+STEP > MAX -> 0, else c+STEP.
//   TRIANGLE: dir UP: c+STEP >= MAX -> MAX, dir<=DOWN; else c+STEP.
//             dir DOWN: c <= STEP -> 0, dir<=UP; else c-STEP.
//   ONESHOT:  c+STEP >= MAX -> MAX, and after that SEND completes -> DONE, o_done=1.
//  DONE: no further loads; o_compare holds MAX; i_mode/i_enable ignored until reset.
//  i_mode sampled when the step is computed; change mid-ramp continues from the
//   current c; dir forced UP when mode != TRIANGLE.
//  Reset mid-handshake: valids drop immediately (async); sequence restarts.
// STRUCTURE
//  Shared include pwm_defs.vh: mode encodings (PWM_MODE_*), FSM state
//   localparams, dir encoding; shared with the PWM core and its bench.
//  Sub-module pwm_event_divider (strobe counter, DIV=HOLD_PERIODS, i_enable,
//   i_clear; outputs 1-clk o_tick); FSM + step arithmetic stay in this module.
// TESTING (bench: TOP_VALUE=7, STEP=3, HOLD_PERIODS=2, STARTUP_DELAY=4)
//  1 Reset release, i_ready=1 -> both valids first high 4 clocks later, one clk,
//    o_compare=0, o_top=7; no valid before that.
//  2 SAW, period_end every 8 clks -> loads 3,6,0,3... one per 2 strobes.
//  3 TRIANGLE -> sequence 3,6,8,5,2,0,3,6,8 (saturate at 8, floor at 0).
//  4 ONESHOT -> 3,6,8 then o_done=1, no further valid over 50 strobes.
//  5 i_ready=0 for 10 clks during SEND -> valid and o_compare stable; extra
//    strobes dropped; step resumes after accept.
//  6 i_enable=0 for 6 strobes, and async reset asserted mid-SEND -> no steps
//    while disabled; reset clears valids same clock, restart matches test 1.

Source files
------------

// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared encodings for the PWM ramp sequencer: ramp modes, sequencer FSM states
// and ramp direction.
package pwm_ramp_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'd0,
    MODE_SAW      = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_ONESHOT  = 2'd3
  } pwm_mode_e;

  typedef enum logic [2:0] {
    ST_STARTUP   = 3'd0,
    ST_LOAD_INIT = 3'd1,
    ST_RUN       = 3'd2,
    ST_SEND      = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } ramp_dir_e;

endpackage

// File: rtl/pwm_ramp_sequencer_divider.sv
// Strobe divider: counts i_strobe pulses while enabled and emits a 1-clock
// o_tick on every DIV-th counted strobe.
module pwm_event_divider #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  input  logic i_strobe,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Combinational so the sequencer can react on the same edge as the final strobe.
  assign o_tick = i_enable && i_strobe && (count == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else if (i_clear || o_tick) begin
      count <= '0;
    end else if (i_enable && i_strobe) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Drives the PWM core's top/compare load interface with a stepped duty ramp
// (sawtooth, triangle, or one-shot fade-in) using a valid/ready handshake.
module pwm_ramp_sequencer
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int TOP_WIDTH     = 8,
  parameter int CMP_WIDTH     = 9,
  parameter int TOP_VALUE     = 255,
  parameter int STEP          = 1,
  parameter int HOLD_PERIODS  = 4,
  parameter int STARTUP_DELAY = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [1:0]           i_mode,
  input  logic                 i_period_end,
  input  logic                 i_ready,
  output logic [TOP_WIDTH-1:0] o_top,
  output logic                 o_top_valid,
  output logic [CMP_WIDTH-1:0] o_compare,
  output logic                 o_compare_valid,
  output logic                 o_done
);

  // One extra bit so c+STEP can exceed MAX without wrapping.
  localparam int EXT_W = CMP_WIDTH + 1;
  localparam logic [EXT_W-1:0]     MAX_EXT  = EXT_W'(TOP_VALUE + 1);
  localparam logic [EXT_W-1:0]     STEP_EXT = EXT_W'(STEP);
  localparam logic [CMP_WIDTH-1:0] MAX_CMP  = CMP_WIDTH'(TOP_VALUE + 1);
  localparam logic [CMP_WIDTH-1:0] STEP_CMP = CMP_WIDTH'(STEP);
  localparam int DLY_W = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STARTUP_DELAY - 1);

  seq_state_e state, state_n;
  ramp_dir_e  dir, dir_n;
  logic [CMP_WIDTH-1:0] compare, compare_n;
  logic       top_valid, top_valid_n;
  logic       cmp_valid, cmp_valid_n;
  logic       done, done_n;
  logic       final_pending, final_pending_n;
  logic [DLY_W-1:0] delay_cnt, delay_cnt_n;

  pwm_mode_e mode;
  logic      tick;
  logic      div_enable;
  logic      div_clear;

  logic [EXT_W-1:0]     sum;
  logic [CMP_WIDTH-1:0] step_value;
  ramp_dir_e            step_dir;
  logic                 step_final;

  assign mode       = pwm_mode_e'(i_mode);
  assign div_enable = i_enable && (state == ST_RUN);
  assign div_clear  = (state == ST_STARTUP) || (state == ST_LOAD_INIT);

  pwm_event_divider #(
    .DIV (HOLD_PERIODS)
  ) u_divider (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (div_enable),
    .i_clear  (div_clear),
    .i_strobe (i_period_end),
    .o_tick   (tick)
  );

  assign sum = {1'b0, compare} + STEP_EXT;

  // Next compare value; direction defaults to UP so non-triangle modes reset it.
  always_comb begin
    step_value = compare;
    step_dir   = DIR_UP;
    step_final = 1'b0;
    case (mode)
      MODE_SAW: begin
        step_value = (sum > MAX_EXT) ? '0 : sum[CMP_WIDTH-1:0];
      end
      MODE_TRIANGLE: begin
        if (dir == DIR_UP) begin
          if (sum >= MAX_EXT) begin
            step_value = MAX_CMP;
            step_dir   = DIR_DOWN;
          end else begin
            step_value = sum[CMP_WIDTH-1:0];
            step_dir   = DIR_UP;
          end
        end else begin
          if (compare <= STEP_CMP) begin
            step_value = '0;
            step_dir   = DIR_UP;
          end else begin
            step_value = compare - STEP_CMP;
            step_dir   = DIR_DOWN;
          end
        end
      end
      MODE_ONESHOT: begin
        if (sum >= MAX_EXT) begin
          step_value = MAX_CMP;
          step_final = 1'b1;
        end else begin
          step_value = sum[CMP_WIDTH-1:0];
        end
      end
      default: begin
        step_value = compare;
      end
    endcase
  end

  always_comb begin
    state_n         = state;
    dir_n           = dir;
    compare_n       = compare;
    top_valid_n     = top_valid;
    cmp_valid_n     = cmp_valid;
    done_n          = done;
    final_pending_n = final_pending;
    delay_cnt_n     = delay_cnt;
    case (state)
      ST_STARTUP: begin
        if (delay_cnt == DLY_LAST) begin
          state_n     = ST_LOAD_INIT;
          top_valid_n = 1'b1;
          cmp_valid_n = 1'b1;
          compare_n   = '0;
        end else begin
          delay_cnt_n = delay_cnt + DLY_W'(1);
        end
      end
      ST_LOAD_INIT: begin
        if (i_ready) begin
          top_valid_n = 1'b0;
          cmp_valid_n = 1'b0;
          state_n     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mode != MODE_TRIANGLE) begin
          dir_n = DIR_UP;
        end
        // HOLD mode lets the divider tick but never produces a step.
        if (tick && (mode != MODE_HOLD)) begin
          compare_n       = step_value;
          dir_n           = step_dir;
          final_pending_n = step_final;
          cmp_valid_n     = 1'b1;
          state_n         = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_ready) begin
          cmp_valid_n = 1'b0;
          if (final_pending) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        done_n = 1'b1;
      end
      default: begin
        state_n = ST_STARTUP;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_STARTUP;
      dir           <= DIR_UP;
      compare       <= '0;
      top_valid     <= 1'b0;
      cmp_valid     <= 1'b0;
      done          <= 1'b0;
      final_pending <= 1'b0;
      delay_cnt     <= '0;
    end else begin
      state         <= state_n;
      dir           <= dir_n;
      compare       <= compare_n;
      top_valid     <= top_valid_n;
      cmp_valid     <= cmp_valid_n;
      done          <= done_n;
      final_pending <= final_pending_n;
      delay_cnt     <= delay_cnt_n;
    end
  end

  assign o_top           = TOP_WIDTH'(TOP_VALUE);
  assign o_top_valid     = top_valid;
  assign o_compare       = compare;
  assign o_compare_valid = cmp_valid;
  assign o_done          = done;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: table of ramp loads per mode plus
// hand-written sequences for backpressure, enable freeze and mid-handshake reset.
module tb_pwm_ramp_sequencer;

  localparam int TOP_WIDTH = 3;
  localparam int CMP_WIDTH = 4;

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic [1:0]           mode;
  logic                 period_end;
  logic                 ready;
  logic [TOP_WIDTH-1:0] top;
  logic                 top_valid;
  logic [CMP_WIDTH-1:0] compare;
  logic                 compare_valid;
  logic                 done;

  int checks;
  int failures;

  typedef struct packed {
    logic       do_reset;
    logic [1:0] mode;
    logic [3:0] exp_cmp;
  } vec_t;

  vec_t vecs [16];

  pwm_ramp_sequencer #(
    .TOP_WIDTH     (TOP_WIDTH),
    .CMP_WIDTH     (CMP_WIDTH),
    .TOP_VALUE     (7),
    .STEP          (3),
    .HOLD_PERIODS  (2),
    .STARTUP_DELAY (4)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_enable        (enable),
    .i_mode          (mode),
    .i_period_end    (period_end),
    .i_ready         (ready),
    .o_top           (top),
    .o_top_valid     (top_valid),
    .o_compare       (compare),
    .o_compare_valid (compare_valid),
    .o_done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic en, input logic rdy);
    mode   = m;
    enable = en;
    ready  = rdy;
  endtask

  task automatic pulseStrobe();
    @(negedge clk);
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
  endtask

  task automatic checkStartup(input string tag);
    int early;
    early = 0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (top_valid || compare_valid) early++;
    end
    checkOutput({tag, "_no_early_valid"}, early, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_top_valid"}, int'(top_valid), 1);
    checkOutput({tag, "_cmp_valid"}, int'(compare_valid), 1);
    checkOutput({tag, "_cmp_zero"}, int'(compare), 0);
    checkOutput({tag, "_top_value"}, int'(top), 7);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_valids_drop"}, int'(top_valid || compare_valid), 0);
  endtask

  task automatic resetAndInit(input string tag);
    @(negedge clk);
    reset      = 1'b1;
    period_end = 1'b0;
    ready      = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkStartup(tag);
  endtask

  task automatic doStep(input string tag, input int exp_cmp);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 6) begin
      repeat (6) @(negedge clk);
      pulseStrobe();
      n++;
      if (compare_valid) got = 1'b1;
    end
    checkOutput({tag, "_load_seen"}, int'(got), 1);
    checkOutput({tag, "_cmp"}, int'(compare), exp_cmp);
    checkOutput({tag, "_strobes"}, n, 2);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int late;
    int unstable;
    int seen;

    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    period_end = 1'b0;
    applyStimulus(2'd1, 1'b1, 1'b1);

    vecs[0]  = '{1'b0, 2'd1, 4'd3};
    vecs[1]  = '{1'b0, 2'd1, 4'd6};
    vecs[2]  = '{1'b0, 2'd1, 4'd0};
    vecs[3]  = '{1'b0, 2'd1, 4'd3};
    vecs[4]  = '{1'b1, 2'd2, 4'd3};
    vecs[5]  = '{1'b0, 2'd2, 4'd6};
    vecs[6]  = '{1'b0, 2'd2, 4'd8};
    vecs[7]  = '{1'b0, 2'd2, 4'd5};
    vecs[8]  = '{1'b0, 2'd2, 4'd2};
    vecs[9]  = '{1'b0, 2'd2, 4'd0};
    vecs[10] = '{1'b0, 2'd2, 4'd3};
    vecs[11] = '{1'b0, 2'd2, 4'd6};
    vecs[12] = '{1'b0, 2'd2, 4'd8};
    vecs[13] = '{1'b1, 2'd3, 4'd3};
    vecs[14] = '{1'b0, 2'd3, 4'd6};
    vecs[15] = '{1'b0, 2'd3, 4'd8};

    $display("[TB] startup after reset release");
    repeat (2) @(negedge clk);
    checkOutput("reset_cmp_valid", int'(compare_valid), 0);
    checkOutput("reset_done", int'(done), 0);
    reset = 1'b0;
    checkStartup("startup");

    $display("[TB] table-driven ramp loads");
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].do_reset) resetAndInit($sformatf("vec%0d_init", i));
      applyStimulus(vecs[i].mode, 1'b1, 1'b1);
      doStep($sformatf("vec%0d", i), int'(vecs[i].exp_cmp));
    end

    $display("[TB] oneshot completion");
    repeat (4) @(negedge clk);
    checkOutput("oneshot_done", int'(done), 1);
    checkOutput("oneshot_hold_max", int'(compare), 8);
    late = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(2'(i % 4), 1'(i % 2), 1'b1);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        period_end = (k == 0);
        if (compare_valid || top_valid) late++;
      end
    end
    period_end = 1'b0;
    checkOutput("oneshot_no_more_loads", late, 0);
    checkOutput("oneshot_done_sticky", int'(done), 1);
    checkOutput("oneshot_cmp_sticky", int'(compare), 8);

    $display("[TB] backpressure during send");
    applyStimulus(2'd1, 1'b1, 1'b1);
    resetAndInit("bp_init");
    applyStimulus(2'd1, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    pulseStrobe();
    repeat (6) @(negedge clk);
    pulseStrobe();
    checkOutput("bp_valid_up", int'(compare_valid), 1);
    checkOutput("bp_cmp", int'(compare), 3);
    unstable = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      period_end = (k == 2) || (k == 5) || (k == 8);
      if (!compare_valid || compare !== 4'd3) unstable++;
    end
    period_end = 1'b0;
    checkOutput("bp_stable", unstable, 0);
    ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_accept", int'(compare_valid), 0);
    doStep("bp_resume", 6);

    $display("[TB] enable freeze and reset mid-send");
    resetAndInit("en_init");
    applyStimulus(2'd1, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    pulseStrobe();
    checkOutput("en_first_strobe_no_load", int'(compare_valid), 0);
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      repeat (6) @(negedge clk);
      pulseStrobe();
      if (compare_valid) seen++;
    end
    checkOutput("en_frozen", seen, 0);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    pulseStrobe();
    checkOutput("en_resume_load", int'(compare_valid), 1);
    checkOutput("en_resume_cmp", int'(compare), 3);
    repeat (2) @(negedge clk);
    ready = 1'b0;
    repeat (6) @(negedge clk);
    pulseStrobe();
    repeat (6) @(negedge clk);
    pulseStrobe();
    checkOutput("midsend_valid", int'(compare_valid), 1);
    checkOutput("midsend_cmp", int'(compare), 6);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_valid_drop", int'(compare_valid), 0);
    checkOutput("async_cmp_clear", int'(compare), 0);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkStartup("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
